shift_pipe_ctrl: RTL and testbench
==================================

Name: shift_pipe_ctrl

Overview:
Flow controller for an M-deep, N-bit-wide rigid shift pipeline. It holds the stage registers and one valid bit per stage. It converts free-running shift-register behaviour into valid/ready streams on both sides, with occupancy tracking, bubble-insertion drain and a synchronous flush. It sits between a producer and the consumer that read through the shift-register datapath, which lets upstream and downstream stall without losing words.

Parameters:
N, 4, data width in bits of each stage
M, 2, pipeline depth in stages, M >= 1

Ports:
Clk  in  1  clock, all state updates on rising edge
Clr_n  in  1  reset, asynchronous, active-low
in_valid  in  1  producer presents in_data
in_ready  out  1  controller accepts in_data this cycle
in_data  in  N  input word
out_valid  out  1  out_data holds a valid word
out_ready  in  1  consumer takes out_data this cycle
out_data  out  N  data of stage M-1
drain  in  1  level; push bubbles to empty the pipe when no input
flush  in  1  pulse; discard all held words
count  out  $clog2(M+1)  number of valid stages
busy  out  1  state != IDLE

Behaviour:
- Reset: the clock is Clk; reset is asynchronous, active-low on Clr_n. Asserting Clr_n clears all valid bits, stage data to 0, count=0 and state=IDLE. Outputs: in_ready=1, out_valid=0, out_data=0, busy=0. Reset mid-stream discards all words immediately.
- stall = vld[M-1] & ~out_ready.
- in_ready = ~stall & ~flush & (state != FLUSH).
- accept = in_valid & in_ready.
- bubble = drain & ~in_valid & (count != 0) & ~stall & ~flush & (state != FLUSH).
- advance = accept | bubble.
- On an advance edge, all stages shift together:
  - stage[0] <= in_data and vld[0] <= accept; a bubble writes vld[0]=0 and leaves data don't-care.
  - stage[k] <= stage[k-1] and vld[k] <= vld[k-1].
- No advance: all stages and valid bits hold.
- Input with no drain: the pipe is rigid. Words move only when a new word enters, so without drain the last M-1 words stay put indefinitely.
- out_valid = vld[M-1] & ~flush. out_data = stage[M-1]. An output transfer occurs when out_valid & out_ready.
- count update is next = count + accept - (vld[M-1] & advance). It never exceeds M and never underflows.
- Latency: a word accepted at edge t reaches out_valid after M-1 further advance edges. With continuous input and out_ready=1, out_valid rises M-1 cycles after the first accept. For M=1, out_valid rises the cycle after accept.
- FSM, 2-bit:
  - IDLE, count==0: accept -> RUN.
  - RUN: drain & ~in_valid -> DRAIN. If count goes to 0 via flush -> FLUSH.
  - DRAIN: accept -> RUN (input has priority over bubbles). Count reaching 0 -> IDLE.
  - FLUSH: lasts one cycle, then -> IDLE unconditionally.
  - flush=1 in any state except reset: on that edge all vld cleared, count=0, state=FLUSH.
- Simultaneous events:
  - flush with in_valid: word not accepted.
  - flush with out_ready: no transfer, because out_valid is forced 0.
  - drain with in_valid: real input wins, no bubble.
  - stall while in_valid: in_ready=0 and nothing moves.
  - Full pipe (count==M) with out_ready=1 and in_valid=1: accept and output in the same cycle; count is unchanged.
- Stage data is not cleared by flush; only the valid bits are.

Optional Feature:
- Macro: SHIFT_PIPE_CTRL_CNT_EN.
- Defined: adds output port words_out [15:0]. It increments on each output transfer, saturates at 16'hFFFF, is cleared by Clr_n, and is not cleared by flush.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- M=3, N=4. Reset, then in_valid=1 with data 15, 14, 8, 1 on consecutive cycles, out_ready=1 -> out_valid first high after the third accept with out_data=15; then 14 on the next accept; count holds at 3.
- M=3: feed 15, 14, 8, then in_valid=0, drain=1 -> outputs 15, 14, 8 on three successive cycles; count goes 3->2->1->0; state DRAIN->IDLE; busy=0 afterwards.
- M=3: pipe full (count=3), out_ready=0, in_valid=1 -> in_ready=0, out_data stable at the head word for 5 cycles. Release out_ready -> single transfer per accept, no word lost or duplicated.
- M=2: two words in, assert flush for 1 cycle with in_valid=1 and out_ready=1 -> no accept, no output transfer; next cycle count=0, state=FLUSH, in_ready=0; the following cycle state=IDLE and in_ready=1.
- Assert Clr_n=0 asynchronously mid-drain with count=2 -> out_valid=0, count=0, busy=0 before the next Clk edge. After release, words 1, 2, 3 stream correctly.
- SHIFT_PIPE_CTRL_CNT_EN defined: after 5 output transfers and one flush -> words_out=5. With words_out preset by force to 16'hFFFF, one more transfer -> it stays 16'hFFFF.

Source files
------------

// File: rtl/shift_pipe_ctrl.sv
// rtl/shift_pipe_ctrl.sv - valid/ready flow controller around an M-deep rigid shift pipeline
// Optional words_out transfer counter is enabled by SHIFT_PIPE_CTRL_CNT_EN.
module shift_pipe_ctrl #(
  parameter int N = 4,
  parameter int M = 2
) (
  input  logic                     Clk,
  input  logic                     Clr_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_data,
  input  logic                     drain,
  input  logic                     flush,
  output logic [$clog2(M+1)-1:0]   count,
  output logic                     busy
`ifdef SHIFT_PIPE_CTRL_CNT_EN
  ,
  output logic [15:0]              words_out
`endif
);

  localparam int CW = $clog2(M+1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   stage [M];
  logic [M-1:0]   vld;
  logic [CW-1:0]  count_next;
  logic           stall;
  logic           flushing;
  logic           accept;
  logic           bubble;
  logic           advance;
  logic           retire;

  // Flush blocks movement both on the pulse edge and during the FLUSH cycle.
  assign stall     = vld[M-1] & ~out_ready;
  assign flushing  = flush | (state == FLUSH);
  assign in_ready  = ~stall & ~flushing;
  assign accept    = in_valid & in_ready;
  assign bubble    = drain & ~in_valid & (count != '0) & ~stall & ~flushing;
  assign advance   = accept | bubble;
  assign retire    = vld[M-1] & advance;

  assign out_valid = vld[M-1] & ~flush;
  assign out_data  = stage[M-1];
  assign busy      = (state != IDLE);

  always_comb begin
    count_next = count;
    if (flush)
      count_next = '0;
    else if (accept && !retire)
      count_next = count + 1'b1;
    else if (!accept && retire)
      count_next = count - 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (drain && !in_valid) state_next = DRAIN;
      DRAIN: begin
        if (accept)
          state_next = RUN;
        else if (count_next == '0)
          state_next = IDLE;
      end
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush)
      state_next = FLUSH;
  end

  // Stage data survives a flush; only the valid bits are dropped.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state <= IDLE;
      count <= '0;
      vld   <= '0;
      for (int k = 0; k < M; k++)
        stage[k] <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (flush) begin
        vld <= '0;
      end else if (advance) begin
        vld[0]   <= accept;
        stage[0] <= in_data;
        for (int k = 1; k < M; k++) begin
          vld[k]   <= vld[k-1];
          stage[k] <= stage[k-1];
        end
      end
    end
  end

`ifdef SHIFT_PIPE_CTRL_CNT_EN
  logic [15:0] words_cnt;

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n)
      words_cnt <= '0;
    else if (out_valid && out_ready && (words_cnt != 16'hFFFF))
      words_cnt <= words_cnt + 16'd1;
  end

  assign words_out = words_cnt;
`endif

endmodule

// File: tb/tb_shift_pipe_ctrl.sv
// tb/tb_shift_pipe_ctrl.sv - directed self-checking bench for shift_pipe_ctrl (M=3, N=4)
module tb_shift_pipe_ctrl;

  localparam int N = 4;
  localparam int M = 3;

  logic         Clk = 1'b0;
  logic         Clr_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_data;
  logic         drain = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   count;
  logic         busy;
`ifdef SHIFT_PIPE_CTRL_CNT_EN
  logic [15:0]  words_out;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  shift_pipe_ctrl #(.N(N), .M(M)) dut (
    .Clk       (Clk),
    .Clr_n     (Clr_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drain     (drain),
    .flush     (flush),
    .count     (count),
    .busy      (busy)
`ifdef SHIFT_PIPE_CTRL_CNT_EN
    ,
    .words_out (words_out)
`endif
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    drain     = 1'b0;
    flush     = 1'b0;
    Clr_n     = 1'b0;
    #2;
    Clr_n     = 1'b1;
    tick();
  endtask

  task automatic feed3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    logic [3:0] w [3];
    w[0] = a; w[1] = b; w[2] = c;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    Clr_n = 1'b0;
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 4'd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge Clk);
    Clr_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    logic [3:0] din [4];
    logic       exp_v [4];
    logic [1:0] exp_c [4];
    din[0] = 4'd15; din[1] = 4'd14; din[2] = 4'd8; din[3] = 4'd1;
    exp_v[0] = 1'b0; exp_v[1] = 1'b0; exp_v[2] = 1'b0; exp_v[3] = 1'b1;
    exp_c[0] = 2'd1; exp_c[1] = 2'd2; exp_c[2] = 2'd3; exp_c[3] = 2'd3;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = din[i];
      #1;
      checks++; if (out_valid !== exp_v[i]) begin errors++; $display("FAIL stream_valid[%0d] got %b want %b", i, out_valid, exp_v[i]); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); end
      tick();
      checks++; if (count !== exp_c[i]) begin errors++; $display("FAIL stream_count[%0d] got %0d want %0d", i, count, exp_c[i]); end
      if (i == 2) begin
        checks++; if (out_data !== 4'd15) begin errors++; $display("FAIL stream_first_data got %0d want 15", out_data); end
      end
    end
    #1;
    checks++; if (out_data !== 4'd14) begin errors++; $display("FAIL stream_second_data got %0d want 14", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_second_valid got %b want 1", out_valid); end
  endtask

  task automatic test_drain();
    logic [3:0] exp_d [3];
    logic [1:0] exp_c [3];
    logic       exp_b [3];
    exp_d[0] = 4'd15; exp_d[1] = 4'd14; exp_d[2] = 4'd8;
    exp_c[0] = 2'd2;  exp_c[1] = 2'd1;  exp_c[2] = 2'd0;
    exp_b[0] = 1'b1;  exp_b[1] = 1'b1;  exp_b[2] = 1'b0;
    do_reset();
    out_ready = 1'b1;
    feed3(4'd15, 4'd14, 4'd8);
    drain = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d[j]) begin errors++; $display("FAIL drain_out[%0d] got v=%b d=%0d want v=1 d=%0d", j, out_valid, out_data, exp_d[j]); end
      tick();
      checks++; if (count !== exp_c[j]) begin errors++; $display("FAIL drain_count[%0d] got %0d want %0d", j, count, exp_c[j]); end
      checks++; if (busy !== exp_b[j]) begin errors++; $display("FAIL drain_busy[%0d] got %b want %b", j, busy, exp_b[j]); end
    end
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid got %b want 0", out_valid); end
    drain = 1'b0;
  endtask

  task automatic test_stall();
    logic [3:0] exp_d [6];
    logic [3:0] nxt [3];
    exp_d[0] = 4'd15; exp_d[1] = 4'd14; exp_d[2] = 4'd8;
    exp_d[3] = 4'd1;  exp_d[4] = 4'd2;  exp_d[5] = 4'd3;
    nxt[0] = 4'd1; nxt[1] = 4'd2; nxt[2] = 4'd3;
    do_reset();
    feed3(4'd15, 4'd14, 4'd8);
    in_valid = 1'b1;
    in_data  = 4'd1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 4'd15 || count !== 2'd3) begin
        errors++; $display("FAIL stall_hold[%0d] got rdy=%b v=%b d=%0d cnt=%0d want rdy=0 v=1 d=15 cnt=3", c, in_ready, out_valid, out_data, count);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 3) begin
        in_valid = 1'b1;
        in_data  = nxt[k];
        drain    = 1'b0;
      end else begin
        in_valid = 1'b0;
        drain    = 1'b1;
      end
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d[k]) begin errors++; $display("FAIL stall_release[%0d] got v=%b d=%0d want v=1 d=%0d", k, out_valid, out_data, exp_d[k]); end
      tick();
    end
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_final got cnt=%0d v=%b want cnt=0 v=0", count, out_valid); end
    drain = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    feed3(4'd5, 4'd6, 4'd7);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'd9;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL flush_state got rdy=%b busy=%b want rdy=0 busy=1", in_ready, busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle_valid got %b want 0", out_valid); end
    tick();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL flush_idle got rdy=%b busy=%b cnt=%0d want rdy=1 busy=0 cnt=0", in_ready, busy, count); end
    tick();
    checks++; if (count !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL flush_reaccept got cnt=%0d busy=%b want cnt=1 busy=1", count, busy); end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_d [3];
    exp_d[0] = 4'd1; exp_d[1] = 4'd2; exp_d[2] = 4'd3;
    do_reset();
    out_ready = 1'b1;
    feed3(4'd15, 4'd14, 4'd8);
    drain = 1'b1;
    tick();
    checks++; if (count !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL areset_pre got cnt=%0d busy=%b want cnt=2 busy=1", count, busy); end
    #2;
    Clr_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 2'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL areset_async got v=%b cnt=%0d busy=%b want v=0 cnt=0 busy=0", out_valid, count, busy);
    end
    drain = 1'b0;
    #2;
    Clr_n = 1'b1;
    tick();
    feed3(4'd1, 4'd2, 4'd3);
    drain = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d[j]) begin errors++; $display("FAIL areset_stream[%0d] got v=%b d=%0d want v=1 d=%0d", j, out_valid, out_data, exp_d[j]); end
      tick();
    end
    checks++; if (count !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL areset_end got cnt=%0d busy=%b want cnt=0 busy=0", count, busy); end
    drain = 1'b0;
  endtask

`ifdef SHIFT_PIPE_CTRL_CNT_EN
  task automatic test_words_out();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    drain    = 1'b1;
    for (int j = 0; j < 3; j++) tick();
    drain = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    checks++; if (words_out !== 16'd5) begin errors++; $display("FAIL words_out_count got %0d want 5", words_out); end
    force dut.words_cnt = 16'hFFFF;
    #1;
    release dut.words_cnt;
    feed3(4'd1, 4'd2, 4'd3);
    in_valid = 1'b1;
    in_data  = 4'd4;
    tick();
    in_valid = 1'b0;
    checks++; if (words_out !== 16'hFFFF) begin errors++; $display("FAIL words_out_sat got %h want ffff", words_out); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_drain();
    test_stall();
    test_flush();
    test_async_reset();
`ifdef SHIFT_PIPE_CTRL_CNT_EN
    test_words_out();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
